// File: rtl/ysyx_mem_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, byte-mask width,
// default base address and the address-legality helper.
package ysyx_mem_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam int unsigned MASK_W = 4;

    localparam logic [31:0] DEFAULT_BASE = 32'h8000_0000;

    // Range check is done on the 33-bit offset so addresses below base or past the
    // top can never wrap around into the array.
    function automatic logic addr_bad(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input int unsigned depth);
        logic [32:0] off;
        logic [32:0] lim;
        off = {1'b0, addr} - {1'b0, base};
        lim = 33'(depth) << 2;
        return (addr[1:0] != 2'b00) || off[32] || (off >= lim);
    endfunction

endpackage

// File: rtl/ysyx_dmem_responder_if.sv
// Request/response bundle between the EXU load/store path (master) and the
// data-memory responder (slave).
interface ysyx_dmem_responder_if;
    import ysyx_mem_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_wen;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic [MASK_W-1:0] req_wmask;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_wen, req_addr, req_wdata, req_wmask, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_wen, req_addr, req_wdata, req_wmask, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/ysyx_dmem_bank.sv
// DEPTH x 32 word array with a single synchronous port and per-byte write enables.
// Read data is registered and only updates on an enabled access.
module ysyx_dmem_bank
    import ysyx_mem_pkg::*;
#(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              en,
    input  logic [MASK_W-1:0] we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            rdata <= mem[idx];
            for (int unsigned i = 0; i < MASK_W; i++) begin
                if (we[i]) begin
                    mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/ysyx_dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, waits LATENCY cycles,
// commits to the bank and holds the response until the requester takes it.
module ysyx_dmem_responder
    import ysyx_mem_pkg::*;
#(
    parameter int unsigned DEPTH   = 1024,
    parameter logic [31:0] BASE    = DEFAULT_BASE,
    parameter int unsigned LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    ysyx_dmem_responder_if.slave  bus
);

    localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    logic [1:0]        state;
    logic [3:0]        cnt;

    logic              q_wen;
    logic [31:0]       q_addr;
    logic [31:0]       q_wdata;
    logic [MASK_W-1:0] q_wmask;

    logic              rd_ok;
    logic              err_q;
    logic [31:0]       bank_rdata;

    logic              accept;
    logic              commit;
    logic              c_wen;
    logic [31:0]       c_addr;
    logic [31:0]       c_wdata;
    logic [MASK_W-1:0] c_wmask;
    logic              c_bad;
    logic [IDX_W-1:0]  c_idx;

    assign bus.req_ready = (state == IDLE) && !rst;
    assign accept        = bus.req_valid && bus.req_ready;

    // With zero latency the commit happens on the accept edge itself, so the bank is
    // fed straight from the request inputs; otherwise from the latched request.
    always_comb begin
        if (state == IDLE) begin
            c_wen   = bus.req_wen;
            c_addr  = bus.req_addr;
            c_wdata = bus.req_wdata;
            c_wmask = bus.req_wmask;
            commit  = accept && (LATENCY == 0);
        end else begin
            c_wen   = q_wen;
            c_addr  = q_addr;
            c_wdata = q_wdata;
            c_wmask = q_wmask;
            commit  = (state == WAIT) && (cnt == '0) && !rst;
        end
    end

    assign c_bad = addr_bad(c_addr, BASE, DEPTH);
    assign c_idx = IDX_W'((c_addr - BASE) >> 2);

    ysyx_dmem_bank #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_bank (
        .clk   (clk),
        .en    (commit && !c_bad),
        .we    (c_wen ? c_wmask : '0),
        .idx   (c_idx),
        .wdata (c_wdata),
        .rdata (bank_rdata)
    );

    always_ff @(posedge clk) begin
        if (accept) begin
            q_wen   <= bus.req_wen;
            q_addr  <= bus.req_addr;
            q_wdata <= bus.req_wdata;
            q_wmask <= bus.req_wmask;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            rd_ok <= 1'b0;
            err_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (LATENCY == 0) begin
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                            cnt   <= LAT_M1;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state <= IDLE;
                        rd_ok <= 1'b0;
                        err_q <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
            if (commit) begin
                rd_ok <= !c_wen && !c_bad;
                err_q <= c_bad;
            end
        end
    end

    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_rdata = rd_ok ? bank_rdata : '0;
    assign bus.rsp_err   = err_q;

endmodule
